// File: rtl/glitcbus_space_arbiter.sv
// GLITCBUS address-space decoder and read-return engine: routes bus strobes to one of
// NSPACE register blocks and returns read data immediately, on ack, or on timeout.
module glitcbus_space_arbiter #(
    parameter int              NSPACE     = 8,
    parameter int              AW         = 16,
    parameter int              DW         = 32,
    parameter int              SPACE_LSB  = 4,
    parameter int              SPACE_BITS = 3,
    parameter logic [NSPACE-1:0] READY_MASK = '1,
    parameter int              TIMEOUT    = 15,
    parameter logic [DW-1:0]   ERR_DATA   = 'hBADADD00
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [AW-1:0]        gb_adr_i,
    input  logic [DW-1:0]        gb_dat_i,
    input  logic                 gb_wr_i,
    input  logic                 gb_rd_i,
    output logic [DW-1:0]        gb_dat_o,
    output logic                 gb_valid_o,
    output logic                 busy_o,
    output logic [NSPACE-1:0]    sel_o,
    output logic [SPACE_LSB-1:0] adr_o,
    output logic [DW-1:0]        dat_o,
    output logic                 wr_o,
    output logic                 rd_o,
    input  logic [NSPACE*DW-1:0] space_dat_i,
    input  logic [NSPACE-1:0]    space_ack_i,
    input  logic                 err_clr_i,
    output logic                 err_o,
    output logic [7:0]           err_count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [7:0]            wait_cnt;
    logic [SPACE_BITS-1:0] cur_idx;

    logic [SPACE_BITS-1:0] idx;
    logic                  mapped;
    logic [NSPACE-1:0]     idx_onehot;
    logic [DW-1:0]         cur_dat;
    logic                  cur_ack;
    logic                  cur_imm;
    logic                  timed_out;
    logic                  err_event;

    assign idx    = gb_adr_i[SPACE_LSB +: SPACE_BITS];
    assign mapped = (int'(idx) < NSPACE);

    // Loop-based muxes keep every index inside the NSPACE range even for unmapped idx.
    always_comb begin
        idx_onehot = '0;
        cur_dat    = '0;
        cur_ack    = 1'b0;
        cur_imm    = 1'b0;
        for (int i = 0; i < NSPACE; i++) begin
            idx_onehot[i] = (idx == SPACE_BITS'(i));
            if (cur_idx == SPACE_BITS'(i)) begin
                cur_dat = space_dat_i[i*DW +: DW];
                cur_ack = space_ack_i[i];
                cur_imm = READY_MASK[i];
            end
        end
    end

    assign timed_out = !cur_imm && !cur_ack && (wait_cnt == 8'(TIMEOUT));

    always_comb begin
        err_event = 1'b0;
        case (state)
            IDLE:    err_event = (gb_wr_i && !mapped) || (gb_rd_i && (gb_wr_i || !mapped));
            WAIT:    err_event = gb_rd_i || gb_wr_i || timed_out;
            DONE:    err_event = gb_rd_i || gb_wr_i;
            default: err_event = 1'b0;
        endcase
    end

    // Strobes in and out are single-cycle pulses with no backpressure; gb_valid_o pulses
    // once per accepted read, the cycle after DONE, and gb_dat_o holds until the next return.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            cur_idx    <= '0;
            gb_dat_o   <= '0;
            gb_valid_o <= 1'b0;
            busy_o     <= 1'b0;
            sel_o      <= '0;
            adr_o      <= '0;
            dat_o      <= '0;
            wr_o       <= 1'b0;
            rd_o       <= 1'b0;
        end else begin
            wr_o       <= 1'b0;
            rd_o       <= 1'b0;
            gb_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    sel_o <= '0;
                    if (gb_wr_i) begin
                        if (mapped) begin
                            wr_o  <= 1'b1;
                            sel_o <= idx_onehot;
                            adr_o <= gb_adr_i[SPACE_LSB-1:0];
                            dat_o <= gb_dat_i;
                        end
                    end else if (gb_rd_i) begin
                        if (mapped) begin
                            rd_o     <= 1'b1;
                            sel_o    <= idx_onehot;
                            adr_o    <= gb_adr_i[SPACE_LSB-1:0];
                            busy_o   <= 1'b1;
                            wait_cnt <= '0;
                            cur_idx  <= idx;
                            state    <= WAIT;
                        end else begin
                            gb_dat_o <= ERR_DATA;
                            state    <= DONE;
                        end
                    end
                end
                WAIT: begin
                    if (cur_imm || cur_ack) begin
                        gb_dat_o <= cur_dat;
                        sel_o    <= '0;
                        busy_o   <= 1'b0;
                        state    <= DONE;
                    end else if (timed_out) begin
                        gb_dat_o <= ERR_DATA;
                        sel_o    <= '0;
                        busy_o   <= 1'b0;
                        state    <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    gb_valid_o <= 1'b1;
                    sel_o      <= '0;
                    busy_o     <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A new error in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_o       <= 1'b0;
            err_count_o <= '0;
        end else if (err_event) begin
            err_o <= 1'b1;
            if (err_clr_i)
                err_count_o <= 8'd1;
            else if (err_count_o != 8'hFF)
                err_count_o <= err_count_o + 8'd1;
        end else if (err_clr_i) begin
            err_o       <= 1'b0;
            err_count_o <= '0;
        end
    end

endmodule

// File: tb/tb_glitcbus_space_arbiter.sv
// Directed bench for glitcbus_space_arbiter: six spaces, space 2 ack-type, others immediate.
module tb_glitcbus_space_arbiter;

    localparam int NSPACE = 6;
    localparam int DW     = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [15:0]       gb_adr;
    logic [DW-1:0]     gb_dat_wr;
    logic              gb_wr;
    logic              gb_rd;
    logic [DW-1:0]     gb_dat_rd;
    logic              gb_valid;
    logic              busy;
    logic [NSPACE-1:0] sel;
    logic [3:0]        adr;
    logic [DW-1:0]     dat;
    logic              wr;
    logic              rd;
    logic [NSPACE*DW-1:0] space_dat;
    logic [NSPACE-1:0] space_ack;
    logic              err_clr;
    logic              err;
    logic [7:0]        err_count;

    int checks = 0;
    int errors = 0;

    glitcbus_space_arbiter #(
        .NSPACE(NSPACE), .AW(16), .DW(DW), .SPACE_LSB(4), .SPACE_BITS(3),
        .READY_MASK(6'b111011), .TIMEOUT(15), .ERR_DATA(32'hBADADD00)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .gb_adr_i(gb_adr), .gb_dat_i(gb_dat_wr), .gb_wr_i(gb_wr), .gb_rd_i(gb_rd),
        .gb_dat_o(gb_dat_rd), .gb_valid_o(gb_valid), .busy_o(busy),
        .sel_o(sel), .adr_o(adr), .dat_o(dat), .wr_o(wr), .rd_o(rd),
        .space_dat_i(space_dat), .space_ack_i(space_ack),
        .err_clr_i(err_clr), .err_o(err), .err_count_o(err_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue a one-cycle strobe; returns one cycle after the DUT sampled it.
    task automatic bus_op(input logic w, input logic r, input logic [15:0] a, input logic [31:0] d);
        gb_adr    = a;
        gb_dat_wr = d;
        gb_wr     = w;
        gb_rd     = r;
        tick();
        gb_wr = 1'b0;
        gb_rd = 1'b0;
    endtask

    initial begin
        int early;
        rst_n     = 1'b0;
        gb_adr    = '0;
        gb_dat_wr = '0;
        gb_wr     = 1'b0;
        gb_rd     = 1'b0;
        space_dat = '0;
        space_ack = '0;
        err_clr   = 1'b0;
        space_dat[1*DW +: DW] = 32'h12345678;
        space_dat[2*DW +: DW] = 32'hCAFEF00D;
        space_dat[4*DW +: DW] = 32'h0BEEF004;
        tick();
        tick();
        check("rst_valid", gb_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sel", sel, 0);
        check("rst_strobes", {wr, rd}, 0);
        check("rst_err", {err, err_count}, 0);
        check("rst_dat", gb_dat_rd, 0);
        rst_n = 1'b1;
        tick();

        // Immediate space read
        bus_op(0, 1, 16'h0014, 0);
        check("imm_rd_o", rd, 1);
        check("imm_sel", sel, 6'h02);
        check("imm_busy", busy, 1);
        tick();
        check("imm_rd_pulse", rd, 0);
        check("imm_valid_early", gb_valid, 0);
        tick();
        check("imm_valid", gb_valid, 1);
        check("imm_dat", gb_dat_rd, 32'h12345678);
        tick();
        check("imm_valid_pulse", gb_valid, 0);
        check("imm_dat_hold", gb_dat_rd, 32'h12345678);

        // Ack space: four WAIT cycles without ack, then ack
        bus_op(0, 1, 16'h0020, 0);
        early = 0;
        for (int k = 0; k < 4; k++) begin
            if (!busy || gb_valid || sel != 6'h04) early++;
            space_ack = (k == 1) ? 6'b000001 : 6'b0;
            tick();
        end
        check("ack_wait_busy", early, 0);
        space_ack = 6'b000100;
        tick();
        space_ack = '0;
        check("ack_done_valid", gb_valid, 0);
        tick();
        check("ack_valid", gb_valid, 1);
        check("ack_dat", gb_dat_rd, 32'hCAFEF00D);
        check("ack_no_err", err, 0);

        // Timeout: valid 18 cycles after the read strobe
        bus_op(0, 1, 16'h0020, 0);
        early = 0;
        for (int k = 1; k < 18; k++) begin
            if (gb_valid) early++;
            if (k < 17) tick();
        end
        check("to_no_early_valid", early, 0);
        tick();
        check("to_valid", gb_valid, 1);
        check("to_dat", gb_dat_rd, 32'hBADADD00);
        check("to_err", {err, err_count}, {1'b1, 8'd1});
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_err", {err, err_count}, 0);

        // Single-cycle write
        bus_op(1, 0, 16'h0043, 32'hA5);
        check("wr_o", wr, 1);
        check("wr_sel", sel, 6'h10);
        check("wr_adr", adr, 3);
        check("wr_dat", dat, 32'hA5);
        check("wr_busy", busy, 0);
        tick();
        check("wr_pulse", {wr, sel}, 0);

        // Overrun: read arriving during WAIT
        bus_op(0, 1, 16'h0020, 0);
        bus_op(0, 1, 16'h0014, 0);
        check("ovr_count", err_count, 1);
        check("ovr_no_rd", rd, 0);
        check("ovr_sel", sel, 6'h04);
        space_ack = 6'b000100;
        tick();
        space_ack = '0;
        tick();
        check("ovr_dat", gb_dat_rd, 32'hCAFEF00D);

        // Write and read together: write wins, one error
        bus_op(1, 1, 16'h0014, 32'h55);
        check("wrrd_wr", {wr, rd, busy}, 3'b100);
        check("wrrd_count", err_count, 2);
        tick();

        // Unmapped read (space 7)
        bus_op(0, 1, 16'h0070, 0);
        check("unm_sel", {sel, busy, rd}, 0);
        check("unm_count", err_count, 3);
        tick();
        check("unm_valid", gb_valid, 1);
        check("unm_dat", gb_dat_rd, 32'hBADADD00);

        // Clear coinciding with a new error (unmapped write)
        err_clr = 1'b1;
        bus_op(1, 0, 16'h0070, 32'h1);
        err_clr = 1'b0;
        check("clr_new_err", {err, err_count}, {1'b1, 8'd1});
        check("unm_wr_none", {wr, sel}, 0);

        // Saturation of the error counter
        gb_adr = 16'h0060;
        gb_wr  = 1'b1;
        for (int k = 0; k < 260; k++) tick();
        gb_wr = 1'b0;
        check("err_sat", err_count, 255);

        // Reset in the middle of WAIT
        bus_op(0, 1, 16'h0020, 0);
        check("rst_mid_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out", {busy, sel, rd, gb_valid, err}, 0);
        early = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (gb_valid) early++;
        end
        check("rst_mid_no_valid", early, 0);
        rst_n = 1'b1;
        tick();
        bus_op(0, 1, 16'h0040, 0);
        check("post_rst_sel", sel, 6'h10);
        tick();
        tick();
        check("post_rst_valid", gb_valid, 1);
        check("post_rst_dat", gb_dat_rd, 32'h0BEEF004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
